// File: rtl/pq_drain_pkg.sv
// pq_drain_pkg: shared types and constants for the priority-queue drain controller
package pq_drain_pkg;
    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_COUNT_WIDTH = 8;
    localparam int BUF_DEPTH       = 2;
    localparam int OCC_W           = $clog2(BUF_DEPTH + 1);
endpackage

// File: rtl/pq_skid_buf.sv
// pq_skid_buf: 2-entry FIFO between the queue pop port and the valid/ready output stream
module pq_skid_buf
    import pq_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [OCC_W-1:0]      occ,
    output logic                  valid,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data
);
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic wp, rp, hs;

    assign valid = occ != '0;
    assign hs    = valid && ready;
    assign data  = mem[rp];

    // single-bit pointers suffice for a depth of two
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
            wp  <= 1'b0;
            rp  <= 1'b0;
            occ <= '0;
        end else begin
            if (push) mem[wp] <= push_data;
            if (push) wp <= ~wp;
            if (hs) rp <= ~rp;
            occ <= occ + OCC_W'(push) - OCC_W'(hs);
        end
    end
endmodule

// File: rtl/pq_drain_ctrl.sv
// pq_drain_ctrl: pops the priority queue head in bursts onto a valid/ready stream.
// Optional PQ_DRAIN_ORDER_CHECK_EN adds a sticky check that popped values never increase.
module pq_drain_ctrl
    import pq_drain_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    input  logic                   i_start,
    input  logic [COUNT_WIDTH-1:0] i_count,
    input  logic                   i_abort,
    input  logic                   i_hold,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [COUNT_WIDTH-1:0] o_xfer_cnt,
    output logic                   o_pq_read,
    input  logic                   i_pq_empty,
    input  logic [DATA_WIDTH-1:0]  i_pq_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_order_err
);
    state_t state, state_nx;
    logic [COUNT_WIDTH-1:0] rem;
    logic [OCC_W-1:0] occ;
    logic cmode, start_acc, drain_end, flush_done, hs;

    assign o_busy    = state != IDLE;
    assign hs        = o_valid && i_ready;
    assign start_acc = state == IDLE && i_start;

    // pop never looks at i_ready; the buffer absorbs the downstream stall
    always_comb begin
        o_pq_read  = state == DRAIN && !i_pq_empty && !i_hold && !i_abort &&
                     occ < OCC_W'(BUF_DEPTH) && (!cmode || rem != '0);
        drain_end  = i_abort || (i_pq_empty && !i_hold) ||
                     (cmode && o_pq_read && rem == COUNT_WIDTH'(1));
        flush_done = occ == '0 || (occ == OCC_W'(1) && hs);
        state_nx   = start_acc ? DRAIN :
                     (state == DRAIN && drain_end) ? FLUSH :
                     (state == FLUSH && flush_done) ? IDLE : state;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            rem        <= '0;
            cmode      <= 1'b0;
            o_xfer_cnt <= '0;
            o_done     <= 1'b0;
        end else begin
            o_done <= state == FLUSH && flush_done;
            if (start_acc) begin
                rem        <= i_count;
                cmode      <= i_count != '0;
                o_xfer_cnt <= '0;
            end else if (o_pq_read) begin
                rem        <= rem - COUNT_WIDTH'(1);
                o_xfer_cnt <= (&o_xfer_cnt) ? o_xfer_cnt : o_xfer_cnt + COUNT_WIDTH'(1);
            end
        end
    end

`ifdef PQ_DRAIN_ORDER_CHECK_EN
    logic [DATA_WIDTH-1:0] prev;
    logic have_prev, err;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            prev      <= '0;
            have_prev <= 1'b0;
            err       <= 1'b0;
        end else if (start_acc) begin
            have_prev <= 1'b0;
            err       <= 1'b0;
        end else if (o_pq_read) begin
            prev      <= i_pq_data;
            have_prev <= 1'b1;
            if (have_prev && i_pq_data > prev) err <= 1'b1;
        end
    end
    assign o_order_err = err;
`else
    assign o_order_err = 1'b0;
`endif

    pq_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (i_CLK),
        .rst       (i_RST),
        .push      (o_pq_read),
        .push_data (i_pq_data),
        .occ       (occ),
        .valid     (o_valid),
        .ready     (i_ready),
        .data      (o_data)
    );
endmodule
